commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
Synthesizable retire-trace capture stage that sits directly downstream of cpu_top's commit/writeback signals. It turns each enabled cycle's commit activity into a typed trace record with the fields the software trace expects: INUM, PC, REG, VALUE and ADDR. Records are buffered in a FIFO and drained over a valid/ready port to the debug/DMA path. The block also keeps the cycle and instruction counters and the halt/timeout status in hardware.

Parameters:
DEPTH, 16, FIFO entries (power of 2, >=2)
TIMEOUT, 100000, cycle count above which timeout asserts
DROP_W, 16, width of dropped-record counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  capture enable
pc  in  32  PC of committing instruction
inst  in  32  committing instruction word
reg_wr  in  1  register file write this cycle
wr_reg  in  5  destination register (inst[26:22])
wr_data  in  32  register write data
mem_rd  in  1  memory read this cycle
mem_wr  in  1  memory write this cycle
mem_addr  in  32  memory address (ALU result)
mem_data  in  32  memory store data
halt  in  1  halt reached commit
rec_valid  out  1  head record available
rec_ready  in  1  consumer accepts head record
rec_kind  out  3  0 NOP, 1 REG, 2 LD, 3 ST, 4 HALT
rec_inum  out  32  instruction number
rec_cycle  out  32  cycle stamp at capture
rec_pc  out  32  PC
rec_reg  out  5  dest register (REG/LD), else 0
rec_addr  out  32  address (LD/ST), else 0
rec_value  out  32  wr_data (REG/LD), mem_data (ST), else 0
cycle_count  out  32  cycles since reset release
inst_count  out  32  records generated (captured plus dropped)
drop_count  out  DROP_W  records lost to a full FIFO, saturating
overflow  out  1  sticky: at least one record dropped
halted  out  1  sticky: HALT record generated
done  out  1  halted and FIFO empty
timeout  out  1  cycle_count > TIMEOUT

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, all outputs 0. rec_* fields read 0 while rec_valid=0.
  - Assertion mid-drain discards the buffered records immediately.
- cycle_count: increments every clk edge while rst_n=1, independent of en; saturates at 2^32-1.
  - timeout: registered compare, asserts the edge after cycle_count reaches TIMEOUT+1; sticky until reset.
- Capture: a capture cycle is any edge with en=1 and halted=0. Exactly one record is generated per capture cycle.
- Kind priority:
  - reg_wr=1: LD if mem_rd=1, else REG.
  - else halt=1: HALT.
  - else mem_wr=1: ST.
  - else NOP.
- rec_inum = inst_count value before increment, so the first record is inum 0.
  - inst_count increments on every capture cycle, even when the record is dropped; gaps in inum expose drops.
- rec_cycle = cycle_count value at the capture edge.
- halt=1 on any capture cycle sets halted, even when the kind is REG/LD.
  - After that, no further records are generated and inst_count freezes.
- FIFO: registered storage, first-word-fall-through.
  - rec_valid = (occupancy != 0), driven from registered state.
  - A record pushed at edge N is visible at the head after edge N; no same-cycle bypass when empty.
- Pop: occurs when rec_valid && rec_ready at the edge.
  - The consumer may hold rec_ready high continuously.
  - rec_* stay stable while rec_valid=1 and rec_ready=0.
- Push when full:
  - With a simultaneous pop: push is accepted.
  - Without a pop: record is dropped, overflow <= 1, drop_count += 1 (saturating at 2^DROP_W-1).
- Pointers wrap modulo DEPTH. Occupancy ranges 0..DEPTH.
- done = halted && !rec_valid.
- en=0: no record, counters other than cycle_count frozen; the FIFO still drains.
- Expected size: about 200 lines RTL.

Test Plan:
1. Release reset at 201 ns, en=1, rec_ready=1, one REG cycle (wr_reg=3, wr_data=0x1234, pc=0x10) -> rec_valid next cycle, kind=1, inum=0, reg=3, value=0x1234, pc=0x10.
2. reg_wr=1, mem_rd=1, wr_reg=5, wr_data=0xBEEF, mem_addr=0x40 -> kind=2 (LD), addr=0x40. Then mem_wr=1, mem_addr=0x44, mem_data=0xCAFE -> kind=3 (ST), value=0xCAFE, reg=0.
3. rec_ready=0, 20 NOP cycles, DEPTH=16 -> 16 records held, overflow=1, drop_count=4, inst_count=20. Drain -> inum 0..15 in order with stable fields under backpressure.
4. FIFO full, rec_ready=1 with NOPs continuing -> no drops; push and pop in the same cycle keep occupancy at 16.
5. halt=1 at the 3rd capture cycle, inputs then keep toggling -> HALT record inum=2, inst_count stays 3, done=1 after drain.
6. Hold en=0 -> timeout asserts after cycle_count=100001. Assert rst_n mid-drain -> rec_valid=0 and all counters 0 immediately, asynchronously.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: turns each enabled commit cycle into a typed trace record,
// buffers records in a first-word-fall-through FIFO and keeps cycle/instruction/drop stats.
module commit_trace_buffer #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 100000,
   parameter int DROP_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [31:0]       pc,
   input  logic [31:0]       inst,
   input  logic              reg_wr,
   input  logic [4:0]        wr_reg,
   input  logic [31:0]       wr_data,
   input  logic              mem_rd,
   input  logic              mem_wr,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_data,
   input  logic              halt,
   output logic              rec_valid,
   input  logic              rec_ready,
   output logic [2:0]        rec_kind,
   output logic [31:0]       rec_inum,
   output logic [31:0]       rec_cycle,
   output logic [31:0]       rec_pc,
   output logic [4:0]        rec_reg,
   output logic [31:0]       rec_addr,
   output logic [31:0]       rec_value,
   output logic [31:0]       cycle_count,
   output logic [31:0]       inst_count,
   output logic [DROP_W-1:0] drop_count,
   output logic              overflow,
   output logic              halted,
   output logic              done,
   output logic              timeout
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   localparam logic [2:0] K_NOP  = 3'd0;
   localparam logic [2:0] K_REG  = 3'd1;
   localparam logic [2:0] K_LD   = 3'd2;
   localparam logic [2:0] K_ST   = 3'd3;
   localparam logic [2:0] K_HALT = 3'd4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [31:0] inum;
      logic [31:0] cycle;
      logic [31:0] pc;
      logic [4:0]  rg;
      logic [31:0] addr;
      logic [31:0] value;
   } rec_t;

   rec_t            r_mem [DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_cycle;
   logic [31:0]     r_inst;
   logic [DROP_W-1:0] r_drop;
   logic            r_ovf;
   logic            r_halted;
   logic            r_timeout;

   rec_t            w_rec;
   rec_t            w_head;
   logic            w_valid;
   logic            w_cap;
   logic            w_pop;
   logic            w_full;
   logic            w_push;
   logic            w_drop;
   logic            w_unused;

   // The instruction word carries nothing the trace record needs beyond wr_reg.
   assign w_unused = ^inst;

   always_comb begin
      w_rec       = '0;
      w_rec.inum  = r_inst;
      w_rec.cycle = r_cycle;
      w_rec.pc    = pc;
      w_rec.kind  = K_NOP;
      if (reg_wr) begin
         w_rec.kind  = mem_rd ? K_LD : K_REG;
         w_rec.rg    = wr_reg;
         w_rec.value = wr_data;
         if (mem_rd) w_rec.addr = mem_addr;
      end else if (halt) begin
         w_rec.kind = K_HALT;
      end else if (mem_wr) begin
         w_rec.kind  = K_ST;
         w_rec.addr  = mem_addr;
         w_rec.value = mem_data;
      end
   end

   assign w_valid = (r_cnt != '0);
   assign w_cap   = en && !r_halted;
   assign w_pop   = w_valid && rec_ready;
   assign w_full  = (r_cnt == CW'(DEPTH));
   // A full FIFO still accepts the push when the head leaves on the same edge.
   assign w_push  = w_cap && (!w_full || w_pop);
   assign w_drop  = w_cap && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_rec;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle   <= '0;
         r_inst    <= '0;
         r_drop    <= '0;
         r_ovf     <= 1'b0;
         r_halted  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         if (r_cycle != '1) r_cycle <= r_cycle + 32'd1;
         if (r_cycle > 32'(TIMEOUT)) r_timeout <= 1'b1;
         if (w_cap) begin
            r_inst <= r_inst + 32'd1;
            if (halt) r_halted <= 1'b1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + 1'b1;
         end
      end
   end

   // Head fields are masked so an empty FIFO presents an all-zero record.
   assign w_head    = w_valid ? r_mem[r_rd] : '0;
   assign rec_valid = w_valid;
   assign rec_kind  = w_head.kind;
   assign rec_inum  = w_head.inum;
   assign rec_cycle = w_head.cycle;
   assign rec_pc    = w_head.pc;
   assign rec_reg   = w_head.rg;
   assign rec_addr  = w_head.addr;
   assign rec_value = w_head.value;

   assign cycle_count = r_cycle;
   assign inst_count  = r_inst;
   assign drop_count  = r_drop;
   assign overflow    = r_ovf;
   assign halted      = r_halted;
   assign done        = r_halted && !w_valid;
   assign timeout     = r_timeout;

endmodule
